// File: rtl/input_debounce.sv
// Two-channel switch debouncer: 2-flop synchronizer plus a four-state qualifier per channel.
// Outputs, rise pulses and fall pulses are registered; stable is a decode of both channels' states.

module input_debounce_chan #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic sw,
   output logic lvl,
   output logic rise,
   output logic fall,
   output logic settled
);

   typedef enum logic [1:0] {
      S_LOW     = 2'd0,
      S_WAIT_HI = 2'd1,
      S_HIGH    = 2'd2,
      S_WAIT_LO = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lvl_q, lvl_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lvl_d   = lvl_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         S_LOW: begin
            if (sync2_q) begin
               state_d = S_WAIT_HI;
               cnt_d   = '0;
            end
         end
         S_WAIT_HI: begin
            if (!sync2_q) begin
               state_d = S_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_HIGH;
               cnt_d   = '0;
               lvl_d   = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_HIGH: begin
            if (!sync2_q) begin
               state_d = S_WAIT_LO;
               cnt_d   = '0;
            end
         end
         S_WAIT_LO: begin
            if (sync2_q) begin
               state_d = S_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_LOW;
               cnt_d   = '0;
               lvl_d   = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_LOW;
            cnt_d   = '0;
            lvl_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= S_LOW;
         cnt_q   <= '0;
         lvl_q   <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= sw;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lvl_q   <= lvl_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign lvl     = lvl_q;
   assign rise    = rise_q;
   assign fall    = fall_q;
   assign settled = (state_q == S_LOW) || (state_q == S_HIGH);

endmodule

module input_debounce #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic sw_a,
   input  logic sw_b,
   output logic a,
   output logic b,
   output logic a_rise,
   output logic a_fall,
   output logic b_rise,
   output logic b_fall,
   output logic stable
);

   logic settled_a, settled_b;

   input_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_chan_a (
      .clk     (clk),
      .rst     (rst),
      .sw      (sw_a),
      .lvl     (a),
      .rise    (a_rise),
      .fall    (a_fall),
      .settled (settled_a)
   );

   input_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_chan_b (
      .clk     (clk),
      .rst     (rst),
      .sw      (sw_b),
      .lvl     (b),
      .rise    (b_rise),
      .fall    (b_fall),
      .settled (settled_b)
   );

   assign stable = settled_a & settled_b;

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce with a run-length reference model checked every cycle.
module tb_input_debounce;

   localparam int D = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sw_a = 1'b0;
   logic sw_b = 1'b0;
   logic a, b, a_rise, a_fall, b_rise, b_fall, stable;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   input_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(5)) dut (
      .clk    (clk),
      .rst    (rst),
      .sw_a   (sw_a),
      .sw_b   (sw_b),
      .a      (a),
      .b      (b),
      .a_rise (a_rise),
      .a_fall (a_fall),
      .b_rise (b_rise),
      .b_fall (b_fall),
      .stable (stable)
   );

   // Reference: a level flips once D+1 consecutive samples (seen two edges late) disagree with it.
   typedef struct {
      logic out;
      logic rise;
      logic fall;
      int   run;
      logic p1;
      logic p2;
   } ch_t;

   ch_t m_a = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
   ch_t m_b = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};

   function automatic ch_t ch_step(input ch_t c, input logic sw, input logic r);
      ch_t  n;
      logic s;
      n      = c;
      n.rise = 1'b0;
      n.fall = 1'b0;
      if (r) begin
         n.out = 1'b0;
         n.run = 0;
         n.p1  = 1'b0;
         n.p2  = 1'b0;
      end else begin
         s    = c.p2;
         n.p2 = c.p1;
         n.p1 = sw;
         if (s != c.out) begin
            n.run = c.run + 1;
            if (n.run == D + 1) begin
               n.out  = ~c.out;
               n.rise = ~c.out;
               n.fall = c.out;
               n.run  = 0;
            end
         end else begin
            n.run = 0;
         end
      end
      return n;
   endfunction

   always @(posedge clk) begin
      m_a <= ch_step(m_a, sw_a, rst);
      m_b <= ch_step(m_b, sw_b, rst);
   end

   task automatic chk(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %b want %b at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_a",      a,      m_a.out);
         chk("model_b",      b,      m_b.out);
         chk("model_a_rise", a_rise, m_a.rise);
         chk("model_a_fall", a_fall, m_a.fall);
         chk("model_b_rise", b_rise, m_b.rise);
         chk("model_b_fall", b_fall, m_b.fall);
         chk("model_stable", stable, (m_a.run == 0) && (m_b.run == 0));
      end
   end

   task automatic do_reset();
      rst  = 1'b1;
      sw_a = 1'b0;
      sw_b = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_a", a, 1'b0);
      chk("rst_b", b, 1'b0);
      chk("rst_pulses", a_rise | a_fall | b_rise | b_fall, 1'b0);
      chk("rst_stable", stable, 1'b1);
      chk_en = 1'b1;
      rst    = 1'b0;
   endtask

   initial begin
      do_reset();

      // sw_a held from edge 0: rise on edge 18 only, b untouched, unstable edges 2..17
      for (int i = 0; i <= 21; i++) begin
         sw_a = 1'b1;
         @(negedge clk);
         chk("s1_a",      a,      i >= 18);
         chk("s1_a_rise", a_rise, i == 18);
         chk("s1_b_any",  b | b_rise | b_fall, 1'b0);
         chk("s1_stable", stable, !(i >= 2 && i <= 17));
      end
      sw_a = 1'b0;
      repeat (25) @(negedge clk);
      chk("s1_a_back", a, 1'b0);
      do_reset();

      // Bounce 1,0,1,0 in 3-edge bursts, final 0->1 sample on edge 12
      for (int i = 0; i <= 32; i++) begin
         sw_a = (i >= 12) || (i < 3) || (i >= 6 && i < 9);
         @(negedge clk);
         chk("s2_a",      a,      i >= 30);
         chk("s2_a_rise", a_rise, i == 30);
      end
      do_reset();

      // sw_b high for exactly D edges: nothing happens
      for (int i = 0; i <= 40; i++) begin
         sw_b = (i < 16);
         @(negedge clk);
         chk("s3_b",    b,               1'b0);
         chk("s3_puls", b_rise | b_fall, 1'b0);
      end
      // sw_b high for D+1 edges: rise at 18, fall at 17+18
      for (int i = 0; i <= 40; i++) begin
         sw_b = (i < 17);
         @(negedge clk);
         chk("s4_b",      b,      i >= 18 && i < 35);
         chk("s4_b_rise", b_rise, i == 18);
         chk("s4_b_fall", b_fall, i == 35);
      end
      do_reset();

      // Both channels rise together, then a chatters while b holds
      for (int i = 0; i <= 20; i++) begin
         sw_a = 1'b1;
         sw_b = 1'b1;
         @(negedge clk);
         chk("s5_a_rise", a_rise, i == 18);
         chk("s5_b_rise", b_rise, i == 18);
      end
      for (int i = 0; i < 40; i++) begin
         sw_a = ((i / 2) % 2) == 0;
         @(negedge clk);
         chk("s5_a_hold", a, 1'b1);
         chk("s5_b_hold", b, 1'b1);
         chk("s5_b_puls", b_rise | b_fall, 1'b0);
      end
      do_reset();

      // Reset pulse mid-qualification (cnt=10 after edge 12) discards it
      for (int i = 0; i <= 34; i++) begin
         sw_a = 1'b1;
         rst  = (i == 13);
         @(negedge clk);
         chk("s6_a",      a,      i >= 32);
         chk("s6_a_rise", a_rise, i == 32);
         if (i == 13) chk("s6_rst_stable", stable, 1'b1);
      end
      rst = 1'b0;
      do_reset();

      // Random bursts of at most D cycles on both channels never qualify
      begin
         int rem_a = 0;
         int rem_b = 0;
         for (int i = 0; i < 10000; i++) begin
            if (rem_a == 0) begin
               sw_a  = ~sw_a;
               rem_a = $urandom_range(1, 16);
            end
            if (rem_b == 0) begin
               sw_b  = ~sw_b;
               rem_b = $urandom_range(1, 16);
            end
            rem_a--;
            rem_b--;
            @(negedge clk);
            chk("s7_quiet", a | b | a_rise | a_fall | b_rise | b_fall, 1'b0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
